ymem_resp: RTL and testbench

Data-memory responder for the MEM stage. It accepts the `MemRead`/`MemWrite` strobes, address and store data from the control/EX side. It performs the access on an internal word-addressed array with a programmable wait latency and holds the pipeline with `stall` until the access completes. Read data returns on `rdata` for the `Mem2Reg` writeback path.

---
 rtl/ymem_resp.sv | 140 ++++++++++++++
 tb/tb_ymem_resp.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ymem_resp.sv
// ============================================================================
// Module      : ymem_resp
// Description : MEM-stage data-memory responder with programmable wait latency.
//               Optional access rejection with a fault pulse: YMEM_FAULT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ymem_resp #(
    parameter int DEPTH = 256,
    parameter int LAT   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done
`ifdef YMEM_FAULT_EN
    ,
    output logic        fault
`endif
);

    localparam int         c_AW  = $clog2(DEPTH);
    localparam logic [3:0] c_LAT = 4'(LAT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_cnt;
    logic              r_op;
    logic [c_AW-1:0]   r_idx;
    logic [31:0]       r_wd;
    logic [31:0]       r_rdata;
    logic              r_faultPend;
    logic [31:0]       r_mem [DEPTH];

    logic              w_req;
    logic              w_reject;
    logic              w_access;

    assign w_req    = MemRead | MemWrite;
    assign w_access = (r_state == S_BUSY) && (r_cnt == 4'd0);

`ifdef YMEM_FAULT_EN
    localparam logic [31:0] c_BYTES = 32'(4 * DEPTH);
    assign w_reject = (addr[1:0] != 2'b00) || (addr >= c_BYTES);
    assign fault    = (r_state == S_DONE) && r_faultPend;
`else
    // Without rejection the low byte bits and the high address bits are don't-care.
    logic w_unusedAddr;
    assign w_unusedAddr = ^{addr[31:c_AW+2], addr[1:0], r_faultPend};
    assign w_reject     = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        stall  = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                stall = w_req;
                if (w_req) begin
                    w_next = w_reject ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                stall = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_op        <= 1'b0;
            r_idx       <= '0;
            r_wd        <= 32'd0;
            r_rdata     <= 32'd0;
            r_faultPend <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_op        <= MemWrite;
                        r_idx       <= addr[c_AW+1:2];
                        r_wd        <= wdata;
                        r_cnt       <= c_LAT;
                        r_faultPend <= w_reject;
                        if (w_reject && !MemWrite) begin
                            r_rdata <= 32'd0;
                        end
                    end
                end
                S_BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else if (!r_op) begin
                        r_rdata <= r_mem[r_idx];
                    end
                end
                S_DONE: begin
                    r_faultPend <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Storage is not reset; a reset coinciding with the access edge suppresses the write.
    always_ff @(posedge clk) begin
        if (rst_n && w_access && r_op) begin
            r_mem[r_idx] <= r_wd;
        end
    end

    assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_ymem_resp.sv
// ============================================================================
// Module      : tb_ymem_resp
// Description : Self-checking bench for ymem_resp; three instances (LAT 2/0/3)
//               share request inputs gated by an instance select.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ymem_resp;

    localparam int DEPTH = 256;
    localparam int LATS [3] = '{2, 0, 3};

    logic        clk;
    logic [2:0]  rstN;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          sel;

    logic [2:0]  selMask;
    logic [2:0]  rdV;
    logic [2:0]  wrV;
    logic [31:0] rdataA [3];
    logic [2:0]  stallA;
    logic [2:0]  doneA;
    logic [2:0]  faultA;
    logic        stallV;
    logic        doneV;
    logic        faultV;
    logic [31:0] rdataV;

    int          checks;
    int          errors;
    logic [31:0] model [3][DEPTH];
    logic [31:0] expRd [3];

    assign selMask = 3'(1 << sel);
    assign rdV     = {3{MemRead}} & selMask;
    assign wrV     = {3{MemWrite}} & selMask;
    assign stallV  = stallA[sel];
    assign doneV   = doneA[sel];
    assign faultV  = faultA[sel];
    assign rdataV  = rdataA[sel];

`ifndef YMEM_FAULT_EN
    assign faultA = 3'b000;
`endif

    ymem_resp #(.DEPTH(DEPTH), .LAT(2)) u_dut0 (
        .clk(clk), .rst_n(rstN[0]), .MemRead(rdV[0]), .MemWrite(wrV[0]),
        .addr(addr), .wdata(wdata), .rdata(rdataA[0]), .stall(stallA[0]),
        .done(doneA[0])
`ifdef YMEM_FAULT_EN
        , .fault(faultA[0])
`endif
    );

    ymem_resp #(.DEPTH(DEPTH), .LAT(0)) u_dut1 (
        .clk(clk), .rst_n(rstN[1]), .MemRead(rdV[1]), .MemWrite(wrV[1]),
        .addr(addr), .wdata(wdata), .rdata(rdataA[1]), .stall(stallA[1]),
        .done(doneA[1])
`ifdef YMEM_FAULT_EN
        , .fault(faultA[1])
`endif
    );

    ymem_resp #(.DEPTH(DEPTH), .LAT(3)) u_dut2 (
        .clk(clk), .rst_n(rstN[2]), .MemRead(rdV[2]), .MemWrite(wrV[2]),
        .addr(addr), .wdata(wdata), .rdata(rdataA[2]), .stall(stallA[2]),
        .done(doneA[2])
`ifdef YMEM_FAULT_EN
        , .fault(faultA[2])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One complete access on instance k, checked cycle by cycle against the model.
    task automatic do_access(input int k, input bit rd, input bit wr,
                             input logic [31:0] a, input logic [31:0] d);
        bit rej;
        int idx;
        int last;
        rej = 1'b0;
`ifdef YMEM_FAULT_EN
        rej = (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
`endif
        idx  = int'((a >> 2) % DEPTH);
        last = rej ? 1 : LATS[k] + 2;
        sel = k; MemRead = rd; MemWrite = wr; addr = a; wdata = d;
        if (wr) begin
            if (!rej) model[k][idx] = d;
        end else begin
            expRd[k] = rej ? 32'd0 : model[k][idx];
        end
        for (int c = 0; c <= last; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end else begin
                #1;
            end
            checks++;
            if ({stallV, doneV} !== ((c == last) ? 2'b01 : 2'b10)) begin
                errors++;
                $display("FAIL timing inst%0d addr=%h cyc%0d: stall,done=%b expected %b",
                         k, a, c, {stallV, doneV}, (c == last) ? 2'b01 : 2'b10);
            end
            if (c == last) begin
                checks++;
                if (rdataV !== expRd[k] || faultV !== rej) begin
                    errors++;
                    $display("FAIL retire inst%0d addr=%h: rdata=%h fault=%b expected rdata=%h fault=%b",
                             k, a, rdataV, faultV, expRd[k], rej);
                end
            end
        end
        MemRead = 1'b0; MemWrite = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({stallV, doneV, faultV} !== 3'b000 || rdataV !== expRd[k]) begin
            errors++;
            $display("FAIL idle_after inst%0d: stall,done,fault=%b rdata=%h expected 000 rdata=%h",
                     k, {stallV, doneV, faultV}, rdataV, expRd[k]);
        end
    endtask

    task automatic test_reset;
        rstN = 3'b000; MemRead = 1'b0; MemWrite = 1'b0; addr = '0; wdata = '0; sel = 0;
        repeat (3) @(posedge clk);
        #1 rstN = 3'b111;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            sel = k; #1;
            checks++;
            if (rdataV !== 32'd0 || doneV !== 1'b0 || stallV !== 1'b0 || faultV !== 1'b0) begin
                errors++;
                $display("FAIL reset inst%0d: rdata=%h done=%b stall=%b fault=%b expected all 0",
                         k, rdataV, doneV, stallV, faultV);
            end
            expRd[k] = 32'd0;
        end
        @(posedge clk); #1;
        sel = 0; MemRead = 1'b1; #1;
        checks++;
        if (stallV !== 1'b1) begin
            errors++;
            $display("FAIL stall_same_cycle: stall=%b expected 1", stallV);
        end
        MemRead = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read;
        do_access(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        do_access(0, 1'b1, 1'b0, 32'h10, 32'h0);
        checks++;
        if (rdataV !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL readback_deadbeef: rdata=%h expected deadbeef", rdataV);
        end
    endtask

    task automatic test_both_high;
        do_access(1, 1'b1, 1'b1, 32'h20, 32'h5);
        do_access(1, 1'b1, 1'b0, 32'h20, 32'h0);
        checks++;
        if (rdataV !== 32'h5) begin
            errors++;
            $display("FAIL both_high_readback: rdata=%h expected 5", rdataV);
        end
    endtask

`ifdef YMEM_FAULT_EN
    task automatic test_fault;
        do_access(0, 1'b1, 1'b0, 32'h3, 32'h0);
        do_access(0, 1'b0, 1'b1, 32'h0, 32'h1234_5678);
        do_access(0, 1'b0, 1'b1, 32'(4 * DEPTH), 32'h0BAD_0BAD);
        do_access(0, 1'b1, 1'b0, 32'h0, 32'h0);
        checks++;
        if (rdataV !== 32'h1234_5678) begin
            errors++;
            $display("FAIL reject_write_kept: rdata=%h expected 12345678", rdataV);
        end
    endtask
`else
    task automatic test_wrap;
        do_access(0, 1'b0, 1'b1, 32'h400, 32'h7);
        do_access(0, 1'b1, 1'b0, 32'h0, 32'h0);
        checks++;
        if (rdataV !== 32'h7) begin
            errors++;
            $display("FAIL wrap_readback: rdata=%h expected 7", rdataV);
        end
    endtask
`endif

    task automatic test_reset_busy;
        int seenDone;
        do_access(2, 1'b0, 1'b1, 32'h44, 32'hA5A5_0001);
        sel = 2; MemWrite = 1'b1; addr = 32'h44; wdata = 32'hFFFF_0002;
        @(posedge clk); #1;
        checks++;
        if (stallV !== 1'b1) begin
            errors++;
            $display("FAIL busy_before_reset: stall=%b expected 1", stallV);
        end
        rstN[2] = 1'b0; MemWrite = 1'b0;
        @(posedge clk); #1;
        rstN[2] = 1'b1;
        expRd[2] = 32'd0;
        checks++;
        if ({stallV, doneV} !== 2'b00 || rdataV !== 32'd0) begin
            errors++;
            $display("FAIL reset_abort: stall,done=%b rdata=%h expected 00 rdata=0",
                     {stallV, doneV}, rdataV);
        end
        seenDone = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (doneV === 1'b1) seenDone++;
        end
        checks++;
        if (seenDone != 0) begin
            errors++;
            $display("FAIL aborted_done: done pulses=%0d expected 0", seenDone);
        end
        do_access(2, 1'b1, 1'b0, 32'h44, 32'h0);
    endtask

    task automatic test_random;
        int k;
        int w;
        int op;
        logic [31:0] a;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 16; j++) begin
                do_access(i, 1'b0, 1'b1, 32'(j * 4), $urandom);
            end
        end
        for (int n = 0; n < 60; n++) begin
            k  = int'($urandom_range(0, 2));
            w  = int'($urandom_range(0, 15));
            op = int'($urandom_range(0, 2));
`ifdef YMEM_FAULT_EN
            a = 32'(w * 4);
            case ($urandom_range(0, 5))
                0: a = a | 32'($urandom_range(1, 3));
                1: a = a + 32'(4 * DEPTH * $urandom_range(1, 4));
                default: ;
            endcase
`else
            a = ($urandom << 10) | 32'(w * 4) | 32'($urandom_range(0, 3));
`endif
            do_access(k, op != 1, op != 0, a, $urandom);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int k = 0; k < 3; k++) expRd[k] = 32'd0;
        test_reset();
        test_write_read();
        test_both_high();
`ifdef YMEM_FAULT_EN
        test_fault();
`else
        test_wrap();
`endif
        test_reset_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
